bus_timer: RTL
==============

Name: bus_timer

Overview:
- Memory-mapped 32-bit timer/compare peripheral on the picorv32 native memory bus, decoded in the top level alongside ROM/RAM/LED/UART (proposed slot 5000-5FFF).
- Provides a free-running prescaled counter, a compare match flag and a level interrupt output, giving firmware delays and periodic ticks.
- Replies with a registered one-cycle-latency ready and read data, like the other bus slaves.

Parameters:
- PRESCALE_WIDTH, 16, width of the PRESCALE register and the prescaler counter.
- RESET_COMPARE, 32'hFFFF_FFFF, reset value of COMPARE.

Ports:
- clk  in  1  system clock (25 MHz).
- rst_n  in  1  reset; asynchronous and active-low.
- cs  in  1  chip select: mem_valid qualified by the top-level address decode.
- addr  in  3  word address, taken from cpu_mem_addr[4:2].
- wdata  in  32  write data.
- wstrb  in  4  byte write strobes; all zero means a read.
- rdata  out  32  read data, registered.
- ready  out  1  transfer acknowledge, registered.
- irq  out  1  level interrupt request.

Behaviour:
- Register map (word offsets):
  - 0 CTRL: bit0 EN, bit1 IRQ_EN, bit2 AUTO_RELOAD; other bits read 0.
  - 1 PRESCALE: PRESCALE_WIDTH bits, zero-extended on read.
  - 2 COUNT: read/write.
  - 3 COMPARE: read/write.
  - 4 STATUS: bit0 MATCH, write-1-to-clear.
  - 5-7: read 0, writes ignored.
- Reset values: CTRL 0, PRESCALE 0, COUNT 0, COMPARE RESET_COMPARE, MATCH 0, prescaler counter 0, rdata 0, ready 0, irq 0.
- Handshake:
  - ready <= cs && !ready, so there is exactly one ready pulse per access. ready rises on the cycle after cs rises and drops on the next cycle.
  - A held cs never acknowledges twice.
  - rdata is loaded on the same edge that sets ready, from the register value before that edge's write. A write and a read in the same access return the old value.
- Writes:
  - Performed on the edge where cs && !ready && wstrb != 0.
  - Each wstrb[i] enables byte i only. Byte lanes above a register's width are ignored.
- Prescaler:
  - While EN=1, the prescaler counts up each cycle.
  - When it equals PRESCALE, it produces a one-cycle tick and returns to 0. PRESCALE=0 gives a tick every cycle; PRESCALE=N gives a tick every N+1 cycles.
  - While EN=0, the prescaler and COUNT hold.
  - Writing PRESCALE or CTRL clears the prescaler counter.
- Tick:
  - If COUNT == COMPARE, set MATCH. Then COUNT <= 0 if AUTO_RELOAD=1, otherwise COUNT <= COUNT+1.
  - Otherwise COUNT <= COUNT+1.
  - Arithmetic is modulo 2^32, so FFFF_FFFF wraps to 0 without a flag.
- Simultaneous events:
  - A software COUNT write on a tick edge wins over increment/reload, for the written bytes only; unwritten bytes take the tick result.
  - A STATUS W1C on the same edge as a new match leaves MATCH=1 (set wins).
  - A write to COMPARE takes effect for the next tick's comparison.
- irq <= MATCH_next && IRQ_EN, registered: it asserts one cycle after MATCH sets. Clearing IRQ_EN drops irq on the next edge while MATCH stays set.
- Reset asserted mid-access: all state returns immediately to reset values, with no ready pulse. An access still pending at release is served normally (ready one cycle later).

Decomposition:
- Shared package holds:
  - register offset constants (TIMER_CTRL=0 … TIMER_STATUS=4);
  - CTRL bit index constants (EN, IRQ_EN, AUTO_RELOAD);
  - top-level address-decode nibble 4'b0101.
- One sub-module, timer_prescaler: PRESCALE_WIDTH counter with enable, synchronous clear, terminal value input and tick output.
- Register file, bus interface and compare logic stay in bus_timer.

Test Plan:
- Reset/read-back: release rst_n, read offsets 0-7 -> rdata 0, 0, 0, FFFF_FFFF, 0, 0, 0, 0; ready exactly 1 cycle after cs on each access; never 2 pulses with cs held 3 cycles.
- Prescaled count: PRESCALE=3, CTRL=1, wait 40 cycles, set CTRL=0, read COUNT -> 10 (±1 per the documented write-edge alignment); a second read 20 cycles later returns the same value.
- Match + auto-reload: PRESCALE=0, COMPARE=5, CTRL=7 -> MATCH sets on the tick where COUNT=5, next COUNT=0; irq rises 1 cycle after MATCH; periodic matches every 6 cycles.
- W1C race: write STATUS=1 on the exact edge of a new match -> MATCH stays 1 and irq stays high; write STATUS=1 again with no match -> irq low next cycle.
- Byte strobes and wrap: write COUNT=FFFF_FFFE with wstrb=F, then wdata=0000_00AA with wstrb=1 -> COUNT=FFFF_FFAA; then COUNT=FFFF_FFFF, PRESCALE=0, EN=1, COMPARE=7 -> next COUNT 0, MATCH 0.
- Async reset mid-access: assert rst_n low while cs is held and before ready -> ready, irq and rdata go 0 without a clock edge, registers return to reset values; after release, the pending read of COMPARE returns FFFF_FFFF with a single ready.

Source files
------------

// File: rtl/bus_timer_pkg.sv
// Shared constants for the bus timer: register offsets, CTRL bit positions,
// the top-level decode nibble, and a byte-lane merge helper.
package bus_timer_pkg;

    localparam logic [2:0] TIMER_CTRL     = 3'd0;
    localparam logic [2:0] TIMER_PRESCALE = 3'd1;
    localparam logic [2:0] TIMER_COUNT    = 3'd2;
    localparam logic [2:0] TIMER_COMPARE  = 3'd3;
    localparam logic [2:0] TIMER_STATUS   = 3'd4;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_IRQ_EN      = 1;
    localparam int CTRL_AUTO_RELOAD = 2;

    localparam logic [3:0] TIMER_DECODE_NIBBLE = 4'b0101;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++)
            if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: counts while enabled, emits a one-cycle tick on reaching the
// terminal value and restarts from zero; clr restarts it at any time.
module timer_prescaler #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] terminal,
    output logic             tick
);

    logic [WIDTH-1:0] cnt;

    assign tick = en && (cnt == terminal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped 32-bit timer/compare peripheral on the picorv32 native bus:
// prescaled free-running COUNT, compare MATCH flag and level irq.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter int          PRESCALE_WIDTH = 16,
    parameter logic [31:0] RESET_COMPARE  = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        irq
);

    logic [2:0]                ctrl, ctrl_next;
    logic [PRESCALE_WIDTH-1:0] prescale, prescale_next;
    logic [31:0]               count, count_tick, count_next;
    logic [31:0]               compare, compare_next;
    logic                      match, match_next;
    logic [31:0]               rd_mux;
    logic                      access, wr, presc_clr, tick, hit;

    // One access per cs assertion: the ready cycle blocks a second acknowledge.
    assign access    = cs && !ready;
    assign wr        = access && (wstrb != 4'b0000);
    assign presc_clr = wr && (addr == TIMER_CTRL || addr == TIMER_PRESCALE);

    timer_prescaler #(.WIDTH(PRESCALE_WIDTH)) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (ctrl[CTRL_EN]),
        .clr      (presc_clr),
        .terminal (prescale),
        .tick     (tick)
    );

    assign hit = tick && (count == compare);

    always_comb begin
        count_tick = count;
        if (tick)
            count_tick = (hit && ctrl[CTRL_AUTO_RELOAD]) ? 32'd0 : count + 32'd1;

        ctrl_next     = ctrl;
        prescale_next = prescale;
        count_next    = count_tick;
        compare_next  = compare;
        match_next    = match;

        if (wr) begin
            case (addr)
                TIMER_CTRL:     if (wstrb[0]) ctrl_next = wdata[2:0];
                TIMER_PRESCALE: begin
                    for (int i = 0; i < PRESCALE_WIDTH; i++)
                        if (wstrb[i/8]) prescale_next[i] = wdata[i];
                end
                // Unwritten COUNT bytes keep the tick result.
                TIMER_COUNT:    count_next   = byte_merge(count_tick, wdata, wstrb);
                TIMER_COMPARE:  compare_next = byte_merge(compare, wdata, wstrb);
                TIMER_STATUS:   if (wstrb[0] && wdata[0]) match_next = 1'b0;
                default: ;
            endcase
        end

        // A new match beats a simultaneous W1C.
        if (hit) match_next = 1'b1;
    end

    always_comb begin
        rd_mux = '0;
        case (addr)
            TIMER_CTRL:     rd_mux = {29'd0, ctrl};
            TIMER_PRESCALE: rd_mux = 32'(prescale);
            TIMER_COUNT:    rd_mux = count;
            TIMER_COMPARE:  rd_mux = compare;
            TIMER_STATUS:   rd_mux = {31'd0, match};
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl     <= '0;
            prescale <= '0;
            count    <= '0;
            compare  <= RESET_COMPARE;
            match    <= 1'b0;
            irq      <= 1'b0;
            rdata    <= '0;
            ready    <= 1'b0;
        end else begin
            ctrl     <= ctrl_next;
            prescale <= prescale_next;
            count    <= count_next;
            compare  <= compare_next;
            match    <= match_next;
            irq      <= match_next && ctrl[CTRL_IRQ_EN];
            ready    <= access;
            if (access) rdata <= rd_mux;
        end
    end

endmodule
